// File: rtl/poly_bram_reader.sv
// Streams all 2**AW coefficients out of the coefficient BRAM in linear or bit-reversed
// order onto a valid/ready stream. Reads are only issued when the 2-entry FIFO has room.
module poly_bram_reader #(
    parameter int AW = 8,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bitrev,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t        r_state;
    logic          r_bitrev;
    logic [AW-1:0] r_idx;
    logic          r_inflight;
    logic          r_inflightLast;
    logic [DW-1:0] r_fifoData [2];
    logic [1:0]    r_fifoLast;
    logic          r_head;
    logic [1:0]    r_count;
    logic          r_done;

    logic          w_pop;
    logic          w_issue;
    logic          w_lastIdx;
    logic          w_tail;
    logic [AW-1:0] w_idxRev;

    always_comb begin
        w_idxRev = '0;
        for (int b = 0; b < AW; b++) begin
            w_idxRev[b] = r_idx[AW-1-b];
        end
    end

    // A read may only be issued if its data is guaranteed a FIFO slot when it returns.
    assign w_pop     = m_valid && m_ready;
    assign w_lastIdx = (r_idx == {AW{1'b1}});
    assign w_issue   = (r_state == S_RUN) &&
                       (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));
    assign w_tail    = r_head ^ r_count[0];

    assign raddr   = r_bitrev ? w_idxRev : r_idx;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign m_valid = (r_count != 2'd0);
    assign m_data  = r_fifoData[r_head];
    assign m_last  = m_valid && r_fifoLast[r_head];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_bitrev       <= 1'b0;
            r_idx          <= '0;
            r_inflight     <= 1'b0;
            r_inflightLast <= 1'b0;
            r_fifoData[0]  <= '0;
            r_fifoData[1]  <= '0;
            r_fifoLast     <= '0;
            r_head         <= 1'b0;
            r_count        <= '0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bitrev <= bitrev;
                        r_idx    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // idx parks at N-1 after the final issue so raddr stays put while draining.
                    if (w_issue) begin
                        if (w_lastIdx) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && m_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            r_inflight     <= w_issue;
            r_inflightLast <= w_issue && w_lastIdx;

            if (r_inflight) begin
                r_fifoData[w_tail] <= rdata;
                r_fifoLast[w_tail] <= r_inflightLast;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_poly_bram_reader.sv
// Bench for poly_bram_reader: a BRAM model plus an expected-beat table checked on every
// cycle the stream is valid, with directed runs for ordering, stalls, reset and restarts.
module tb_poly_bram_reader;

    localparam int AW = 8;
    localparam int DW = 12;
    localparam int N  = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          bitrev;
    logic          busy;
    logic          done;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          mValid;
    logic          mReady;
    logic [DW-1:0] mData;
    logic          mLast;

    int memArr  [N];
    int expData [N];
    int beatCnt;
    int total;
    int bad;
    int doneCount;
    int curIdx;
    int guard;
    int doneBase;
    bit runActive;
    bit runBitrev;
    bit prevStall;

    always #5 clk = ~clk;

    poly_bram_reader #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bitrev  (bitrev),
        .busy    (busy),
        .done    (done),
        .raddr   (raddr),
        .rdata   (rdata),
        .m_valid (mValid),
        .m_ready (mReady),
        .m_data  (mData),
        .m_last  (mLast)
    );

    always @(posedge clk) rdata <= DW'(memArr[raddr]);

    function automatic int revIdx(input int k);
        int r = 0;
        int v = k;
        for (int b = 0; b < AW; b++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The head of the stream must always be the next beat still owed to the consumer.
    always @(negedge clk) begin
        if (done) doneCount++;
        if (runActive) begin
            curIdx = runBitrev ? revIdx(int'(raddr)) : int'(raddr);
            checkOutput("outstandingReads", int'(curIdx <= beatCnt + 2), 1);
            if (prevStall) checkOutput("validHeldInStall", mValid, 1);
            if (mValid) begin
                if (beatCnt < N) begin
                    checkOutput("beatData", mData, expData[beatCnt]);
                    checkOutput("beatLast", mLast, int'(beatCnt == N - 1));
                end else begin
                    checkOutput("extraBeat", mValid, 0);
                end
            end
            if (mValid && mReady) beatCnt++;
            prevStall = mValid && !mReady;
        end else begin
            prevStall = 1'b0;
        end
    end

    task automatic applyStimulus(input bit br);
        runActive = 1'b0;
        runBitrev = br;
        beatCnt   = 0;
        for (int k = 0; k < N; k++) begin
            expData[k] = memArr[br ? revIdx(k) : k];
        end
        start  = 1'b1;
        bitrev = br;
        tick();
        start     = 1'b0;
        bitrev    = ~br;
        runActive = 1'b1;
        checkOutput("busyAfterStart", busy, 1);
        checkOutput("validAfterE0", mValid, 0);
        tick();
        checkOutput("validAfterE1", mValid, 0);
        tick();
        checkOutput("validAfterE2", mValid, 1);
    endtask

    task automatic waitDone(input int budget, input int expCycles, input bit rnd, input int startCyc);
        int cyc = startCyc;
        while (!done && cyc < budget) begin
            if (rnd) mReady = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        mReady = 1'b1;
        checkOutput("doneSeen", done, 1);
        checkOutput("beatsAtDone", beatCnt, N);
        checkOutput("busyAtDone", busy, 0);
        if (expCycles > 0) checkOutput("startToDoneCycles", cyc, expCycles);
    endtask

    task automatic checkResetValues();
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstValid", mValid, 0);
        checkOutput("rstLast", mLast, 0);
        checkOutput("rstData", mData, 0);
        checkOutput("rstRaddr", raddr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL globalTimeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        total = 0; bad = 0; doneCount = 0; beatCnt = 0;
        runActive = 1'b0; prevStall = 1'b0; runBitrev = 1'b0;
        rst = 1'b1; start = 1'b0; bitrev = 1'b0; mReady = 1'b1;
        for (int i = 0; i < N; i++) memArr[i] = (13 * i) % 3329;
        repeat (3) tick();
        checkResetValues();
        rst = 1'b0;
        tick();

        $display("[TB] linear order, ready held high");
        applyStimulus(1'b0);
        checkOutput("modelLinear254", expData[254], 3302);
        checkOutput("modelLinear255", expData[255], 3315);
        waitDone(600, N + 3, 1'b0, 3);
        tick();
        checkOutput("donePulseWidth", done, 0);

        $display("[TB] bit-reversed order");
        applyStimulus(1'b1);
        checkOutput("modelRev1", expData[1], 1664);
        checkOutput("modelRev2", expData[2], 832);
        checkOutput("modelRev255", expData[255], 3315);
        waitDone(600, N + 3, 1'b0, 3);
        tick();

        $display("[TB] random backpressure");
        void'($urandom(32'd2024));
        applyStimulus(1'b0);
        waitDone(3000, -1, 1'b1, 3);
        tick();

        $display("[TB] stall right after start");
        mReady = 1'b0;
        applyStimulus(1'b0);
        repeat (17) tick();
        checkOutput("stallRaddrFrozen", raddr, 2);
        checkOutput("stallHeadValid", mValid, 1);
        checkOutput("stallHeadData", mData, 0);
        mReady = 1'b1;
        waitDone(600, -1, 1'b0, 0);
        tick();

        $display("[TB] reset mid-stream");
        applyStimulus(1'b0);
        guard = 0;
        while (beatCnt < 101 && guard < 1000) begin
            tick();
            guard++;
        end
        checkOutput("reachedBeat100", beatCnt, 101);
        rst = 1'b1;
        mReady = 1'b0;
        runActive = 1'b0;
        tick();
        checkResetValues();
        rst = 1'b0;
        mReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("noStrayBeat", mValid, 0);
        end
        applyStimulus(1'b0);
        waitDone(600, N + 3, 1'b0, 3);
        tick();

        $display("[TB] start while busy, then start on done cycle");
        doneBase = doneCount;
        applyStimulus(1'b0);
        guard = 0;
        while (beatCnt < 10 && guard < 1000) begin
            tick();
            guard++;
        end
        start = 1'b1; bitrev = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (beatCnt < 255 && guard < 1000) begin
            tick();
            guard++;
        end
        start = 1'b1; bitrev = 1'b1;
        tick();
        start = 1'b0; bitrev = 1'b0;
        waitDone(600, -1, 1'b0, 0);
        applyStimulus(1'b1);
        waitDone(600, N + 3, 1'b0, 3);
        tick();
        checkOutput("doneAfterRestart", done, 0);
        checkOutput("donesForTwoRuns", doneCount - doneBase, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/poly_bram_reader.md
# poly_bram_reader

Streaming read-out stage placed directly downstream of the 256×12 coefficient BRAM in the Kyber polynomial multiplier. After a `start` pulse it walks every BRAM address in linear or bit-reversed order and absorbs the BRAM's 1-cycle read latency. It delivers the 12-bit coefficients on a valid/ready stream with full backpressure support and no lost or duplicated beats. A 2-entry output FIFO with credit-gated read issue lets it sustain 1 coefficient/cycle while `m_ready` is high.

## Interface
- `AW`, 8: address width; polynomial length N = 2**AW (256).
- `DW`, 12: coefficient width.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to stream the whole polynomial; ignored while `busy`.
- `bitrev`  in  1  address order select, sampled with `start`: 0 = linear, 1 = AW-bit bit-reversed.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last beat is accepted.
- `raddr`  out  AW  BRAM read address.
- `rdata`  in  DW  BRAM `dout`, valid the cycle after `raddr` is sampled.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DW  coefficient.
- `m_last`  out  1  high with the beat for issue index N-1.

## Operation
- The FSM has three states:
  - IDLE: when `start`=1 and `rst`=0, latch `bitrev`, clear the index counter `idx`, and go to RUN.
  - RUN: issue reads. After the read of `idx`=N-1 is issued, go to DRAIN.
  - DRAIN: no issues. When the beat with `m_last` is accepted, go to IDLE and pulse `done` in the next cycle.
- A handshake occurs when `m_valid && m_ready`; it pops the FIFO head.
- `raddr` = `idx` in linear mode, or bit-reverse(`idx`) over AW bits in bit-reversed mode. `raddr` holds its value when no read is issued.
- Issue rule for a cycle in RUN: `issue` = (fifo_count + inflight − pop) < 2.
  - `inflight` is a 1-bit register: 1 if a read was issued in the previous cycle.
  - `pop` is the handshake in the current cycle.
  - `issue` increments `idx`.
- When `inflight`=1, `rdata` is written to the FIFO tail at the next edge together with its `last` flag (idx was N-1). The issue rule guarantees this write never overflows.
- FIFO push and pop in the same cycle: count is unchanged and order is preserved.
- `m_data` and `m_last` come from the FIFO head. While `m_valid`=1 and `m_ready`=0 they stay stable.
- `start` while `busy` is ignored: no restart and no state change.
- Reset, including mid-stream: the state returns to IDLE, the FIFO is emptied, `inflight` is cleared, and the pending BRAM read is discarded.
  - Reset values: `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `raddr`=0.
- BRAM contents are not modified. Any writes to the BRAM during a stream are the caller's responsibility.

## Timing
- E0 = edge sampling `start`=1.
  - `busy`=1 and the first `raddr` is presented after E0.
  - The BRAM samples it at E1.
  - The FIFO captures `rdata` at E2.
  - `m_valid`=1 after E2. The latency from `start` to the first beat is 3 cycles.
- With `m_ready` held at 1, beats are contiguous: N beats in N cycles, and `m_last` is on beat N-1.
- Last handshake at edge Ek: `done`=1 and `busy`=0 in the cycle after Ek. `done` lasts exactly 1 cycle.
  - The minimum total time from `start` to `done` is N+3 cycles.
- A new `start` is accepted in the cycle where `done`=1 (state is IDLE).
- When `m_ready` rises after a stall, the first beat transfers the same cycle. No bubble is inserted when FIFO count ≥ 1.

## Test plan
- Linear, `m_ready`=1, BRAM preloaded with mem[i] = (13·i) mod 3329 → 256 contiguous beats with data 0, 13, 26, …, 3302 (i=254), 3315 (i=255). `m_valid` first seen 3 cycles after `start`. `m_last` only on beat 255. `done` 1 cycle later.
- Bit-reversed with the same contents → beat k carries mem[bitrev8(k)]: beat 1 = mem[128] = 1664, beat 2 = mem[64] = 832, and beat 255 = mem[255] with `m_last`.
- Random `m_ready` (50% duty, seeded) → the exact 256-value sequence with no loss or duplication.
  - Check every cycle that fifo_count + inflight ≤ 2.
  - `m_data`/`m_last` must hold stable while stalled.
- `m_ready`=0 for 20 cycles right after `start` → exactly 2 reads are issued (mem[0], mem[1]), then `raddr` freezes. On release, beats resume back-to-back from value 0.
- `rst` pulsed after beat 100 is accepted → in the next cycle `m_valid`=0, `busy`=0, `raddr`=0, with no stray beat afterwards. A subsequent `start` restreams from mem[0].
- `start` re-pulsed at beats 10 and 255 while `busy` → no effect, with a single `done` per run. A `start` on the `done` cycle begins a new run with correct 3-cycle latency.
